// File: rtl/acc_rf_pkg.sv
// Shared sizing and types for the accumulator register file and its load scoreboard.
package acc_rf_pkg;
  localparam int W     = 8;
  localparam int D     = 4;
  localparam int IMM_W = 4;
  localparam int N     = 1 << D;

  typedef logic [D-1:0] reg_idx_t;
  typedef logic [W-1:0] data_t;
  typedef logic [D:0]   cnt_t;

  function automatic data_t imm_zext(reg_idx_t idx);
    return data_t'(idx[IMM_W-1:0]);
  endfunction
endpackage

// File: rtl/acc_rf_scoreboard.sv
// Tracks in-flight loads per register: pending bits, outstanding count, sticky
// protocol error, and the hazard stall seen by the core.
module acc_rf_scoreboard
  import acc_rf_pkg::*;
(
  input  logic     clk_i,
  input  logic     rst_n_i,
  input  reg_idx_t reg_index_i,
  input  logic     imme_value_i,
  input  logic     reg_write_i,
  input  logic     ld_issue_i,
  input  logic     ret_acc_i,
  input  reg_idx_t ld_ret_index_i,
  output logic     ret_wr_o,
  output logic     stall_o,
  output cnt_t     outstanding_o,
  output logic     err_o
);

  logic [N-1:0] pend_q, pend_d;
  cnt_t         cnt_q, cnt_d;
  logic         err_q, err_d;
  logic         ret_hit, ret_ok, issue_ok;

  // A return accepted this cycle already resolves the hazard on its entry.
  assign ret_hit  = ret_acc_i && (ld_ret_index_i == reg_index_i);
  assign stall_o  = pend_q[reg_index_i] && !ret_hit && (reg_index_i != '0)
                    && (!imme_value_i || reg_write_i || ld_issue_i);
  assign ret_ok   = ret_acc_i && pend_q[ld_ret_index_i];
  assign issue_ok = ld_issue_i && !stall_o && (reg_index_i != '0);
  assign ret_wr_o = ret_ok;

  always_comb begin
    pend_d = pend_q;
    cnt_d  = cnt_q;
    err_d  = err_q;
    if (ret_ok)   pend_d[ld_ret_index_i] = 1'b0;
    if (issue_ok) pend_d[reg_index_i]    = 1'b1;
    case ({issue_ok, ret_ok})
      2'b10:   cnt_d = cnt_q + cnt_t'(1);
      2'b01:   cnt_d = cnt_q - cnt_t'(1);
      default: cnt_d = cnt_q;
    endcase
    if ((ld_issue_i && reg_index_i == '0) || (ret_acc_i && !pend_q[ld_ret_index_i]))
      err_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pend_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  assign outstanding_o = cnt_q;
  assign err_o         = err_q;

endmodule

// File: rtl/acc_reg_file_sb.sv
// Register file with accumulator at entry 0, split-transaction load-return port
// and per-register pending scoreboard guarding RAW/WAW hazards.
module acc_reg_file_sb
  import acc_rf_pkg::*;
(
  input  logic     clk_i,
  input  logic     rst_n_i,
  input  logic     acc_write_i,
  input  logic     reg_write_i,
  input  logic     imme_value_i,
  input  logic     ld_issue_i,
  input  reg_idx_t reg_index_i,
  input  data_t    data_in_i,
  input  logic     ld_ret_valid_i,
  input  reg_idx_t ld_ret_index_i,
  input  data_t    ld_ret_data_i,
  output logic     ld_ret_ready_o,
  output data_t    acc_out_o,
  output data_t    reg_out_o,
  output logic     stall_o,
  output cnt_t     outstanding_o,
  output logic     err_o
);

  data_t regs_q [N];
  data_t regs_d [N];
  logic  ret_acc, ret_wr;

  // Core write to the same entry wins; memory must retry the return.
  assign ld_ret_ready_o = !((reg_write_i && !ld_issue_i && (reg_index_i == ld_ret_index_i))
                            || (acc_write_i && (ld_ret_index_i == '0)));
  assign ret_acc = ld_ret_valid_i && ld_ret_ready_o;

  acc_rf_scoreboard u_sb (
    .clk_i          (clk_i),
    .rst_n_i        (rst_n_i),
    .reg_index_i    (reg_index_i),
    .imme_value_i   (imme_value_i),
    .reg_write_i    (reg_write_i),
    .ld_issue_i     (ld_issue_i),
    .ret_acc_i      (ret_acc),
    .ld_ret_index_i (ld_ret_index_i),
    .ret_wr_o       (ret_wr),
    .stall_o        (stall_o),
    .outstanding_o  (outstanding_o),
    .err_o          (err_o)
  );

  always_comb begin
    regs_d = regs_q;
    if (!stall_o) begin
      if (acc_write_i)
        regs_d[0] = data_in_i;
      else if (reg_write_i && !ld_issue_i && (reg_index_i != '0))
        regs_d[reg_index_i] = data_in_i;
    end
    if (ret_wr) regs_d[ld_ret_index_i] = ld_ret_data_i;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) regs_q <= '{default: '0};
    else          regs_q <= regs_d;
  end

  assign acc_out_o = regs_q[0];
  assign reg_out_o = imme_value_i                                 ? imm_zext(reg_index_i)
                   : (reg_index_i == '0)                          ? '0
                   : (ret_acc && (ld_ret_index_i == reg_index_i)) ? ld_ret_data_i
                   :                                                regs_q[reg_index_i];

endmodule

// File: tb/tb_acc_reg_file_sb.sv
// Randomized and directed bench for acc_reg_file_sb against a behavioural register-file model.
module tb_acc_reg_file_sb;
  logic       clk, rst_n;
  logic       acc_write, reg_write, imme_value, ld_issue, ld_ret_valid;
  logic [3:0] reg_index, ld_ret_index;
  logic [7:0] data_in, ld_ret_data;
  logic       ld_ret_ready, stall, err;
  logic [7:0] acc_out, reg_out;
  logic [4:0] outstanding;

  int errors = 0;
  int checks = 0;

  logic [7:0] m_reg [16];
  bit         m_pend [16];
  int         m_out;
  bit         m_err;

  acc_reg_file_sb dut (
    .clk_i(clk), .rst_n_i(rst_n), .acc_write_i(acc_write), .reg_write_i(reg_write),
    .imme_value_i(imme_value), .ld_issue_i(ld_issue), .reg_index_i(reg_index),
    .data_in_i(data_in), .ld_ret_valid_i(ld_ret_valid), .ld_ret_index_i(ld_ret_index),
    .ld_ret_data_i(ld_ret_data), .ld_ret_ready_o(ld_ret_ready), .acc_out_o(acc_out),
    .reg_out_o(reg_out), .stall_o(stall), .outstanding_o(outstanding), .err_o(err)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  function automatic bit m_ready();
    return !((reg_write && !ld_issue && reg_index == ld_ret_index) || (acc_write && ld_ret_index == 0));
  endfunction

  function automatic bit m_ret_acc();
    return ld_ret_valid && m_ready();
  endfunction

  function automatic bit m_stall();
    int i = int'(reg_index);
    bit busy;
    if (i == 0) return 0;
    busy = m_pend[i] && !(m_ret_acc() && int'(ld_ret_index) == i);
    return busy && (!imme_value || reg_write || ld_issue);
  endfunction

  function automatic logic [7:0] m_regout();
    if (imme_value) return {4'h0, reg_index};
    if (reg_index == 0) return 8'h00;
    if (m_ret_acc() && ld_ret_index == reg_index) return ld_ret_data;
    return m_reg[int'(reg_index)];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 16; i++) begin
      m_reg[i] = 8'h00;
      m_pend[i] = 0;
    end
    m_out = 0;
    m_err = 0;
  endtask

  task automatic drive(bit aw, bit rw, bit imm, bit li, logic [3:0] idx, logic [7:0] din,
                       bit rv, logic [3:0] ri, logic [7:0] rd);
    acc_write = aw; reg_write = rw; imme_value = imm; ld_issue = li; reg_index = idx;
    data_in = din; ld_ret_valid = rv; ld_ret_index = ri; ld_ret_data = rd;
  endtask

  // Advance one clock, applying the architectural effect of the current inputs to the model.
  task automatic step();
    bit st, ra;
    int idx, ri;
    st = m_stall();
    ra = m_ret_acc();
    idx = int'(reg_index);
    ri = int'(ld_ret_index);
    @(posedge clk);
    if (ra) begin
      if (m_pend[ri]) begin
        m_reg[ri] = ld_ret_data;
        m_pend[ri] = 0;
        m_out--;
      end else m_err = 1;
    end
    if (!st) begin
      if (acc_write) m_reg[0] = data_in;
      else if (reg_write && !ld_issue && idx != 0) m_reg[idx] = data_in;
      if (ld_issue) begin
        if (idx == 0) m_err = 1;
        else begin
          m_pend[idx] = 1;
          m_out++;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    #3 rst_n = 0;
    #1;
    checks++; if (acc_out !== 8'h00) begin errors++; $display("FAIL reset_acc actual=%h required=00", acc_out); end
    checks++; if (outstanding !== 5'd0) begin errors++; $display("FAIL reset_outstanding actual=%0d required=0", outstanding); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err actual=%b required=0", err); end
    model_clear();
    for (int i = 1; i < 16; i++) begin
      drive(0, 0, 0, 0, 4'(i), 8'h00, 0, 4'h0, 8'h00);
      #1;
      checks++; if (reg_out !== 8'h00) begin errors++; $display("FAIL reset_entry%0d actual=%h required=00", i, reg_out); end
    end
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_acc_priority();
    drive(1, 1, 0, 0, 4'd5, 8'h3C, 0, 4'h0, 8'h00);
    step();
    drive(0, 0, 0, 0, 4'd5, 8'h00, 0, 4'h0, 8'h00);
    #1;
    checks++; if (acc_out !== 8'h3C) begin errors++; $display("FAIL acc_priority_acc actual=%h required=3c", acc_out); end
    checks++; if (reg_out !== 8'h00) begin errors++; $display("FAIL acc_priority_reg5 actual=%h required=00", reg_out); end
  endtask

  task automatic test_load_bypass();
    drive(0, 0, 0, 1, 4'd3, 8'h00, 0, 4'h0, 8'h00);
    step();
    drive(0, 0, 0, 0, 4'd3, 8'h00, 0, 4'h0, 8'h00);
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL raw_stall actual=%b required=1", stall); end
    checks++; if (outstanding !== 5'd1) begin errors++; $display("FAIL ld_outstanding actual=%0d required=1", outstanding); end
    step();
    drive(0, 0, 0, 0, 4'd3, 8'h00, 1, 4'd3, 8'hA5);
    #1;
    checks++; if (reg_out !== 8'hA5) begin errors++; $display("FAIL bypass_data actual=%h required=a5", reg_out); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL bypass_stall actual=%b required=0", stall); end
    step();
    drive(0, 0, 0, 0, 4'd3, 8'h00, 0, 4'h0, 8'h00);
    #1;
    checks++; if (outstanding !== 5'd0) begin errors++; $display("FAIL ret_outstanding actual=%0d required=0", outstanding); end
    checks++; if (reg_out !== 8'hA5) begin errors++; $display("FAIL ret_stored actual=%h required=a5", reg_out); end
  endtask

  task automatic test_imme();
    drive(0, 0, 0, 1, 4'hB, 8'h00, 0, 4'h0, 8'h00);
    step();
    drive(0, 0, 1, 0, 4'hB, 8'h00, 0, 4'h0, 8'h00);
    #1;
    checks++; if (reg_out !== 8'h0B) begin errors++; $display("FAIL imme_value actual=%h required=0b", reg_out); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL imme_stall actual=%b required=0", stall); end
    drive(0, 0, 0, 0, 4'h0, 8'h00, 1, 4'hB, 8'h66);
    step();
    #1;
    checks++; if (outstanding !== 5'd0) begin errors++; $display("FAIL imme_drain actual=%0d required=0", outstanding); end
  endtask

  task automatic test_ret_conflict();
    drive(0, 1, 0, 0, 4'd7, 8'h11, 1, 4'd7, 8'h77);
    #1;
    checks++; if (ld_ret_ready !== 1'b0) begin errors++; $display("FAIL conflict_ready actual=%b required=0", ld_ret_ready); end
    step();
    drive(0, 0, 0, 0, 4'd7, 8'h00, 1, 4'd7, 8'h77);
    #1;
    checks++; if (ld_ret_ready !== 1'b1) begin errors++; $display("FAIL retry_ready actual=%b required=1", ld_ret_ready); end
    step();
    drive(0, 0, 0, 0, 4'd7, 8'h00, 0, 4'h0, 8'h00);
    #1;
    checks++; if (reg_out !== 8'h11) begin errors++; $display("FAIL conflict_core_data actual=%h required=11", reg_out); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL conflict_stale_err actual=%b required=1", err); end
  endtask

  task automatic test_stale_ret();
    drive(0, 0, 0, 0, 4'd0, 8'h00, 1, 4'd9, 8'h5A);
    step();
    drive(0, 0, 0, 0, 4'd9, 8'h00, 0, 4'h0, 8'h00);
    #1;
    checks++; if (reg_out !== 8'h00) begin errors++; $display("FAIL stale_reg9 actual=%h required=00", reg_out); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL stale_err actual=%b required=1", err); end
    repeat (3) step();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL stale_err_sticky actual=%b required=1", err); end
  endtask

  task automatic test_random(int n);
    logic [3:0] ri;
    int base;
    bit found;
    for (int c = 0; c < n; c++) begin
      ri = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) != 0) begin
        base = $urandom_range(0, 15);
        found = 0;
        for (int k = 0; k < 16; k++)
          if (!found && m_pend[(base + k) % 16]) begin
            ri = 4'((base + k) % 16);
            found = 1;
          end
      end
      drive($urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 4) == 0, 4'($urandom_range(0, 15)), 8'($urandom),
            $urandom_range(0, 2) == 0, ri, 8'($urandom));
      #1;
      checks++; if (ld_ret_ready !== m_ready()) begin errors++; $display("FAIL rnd_ready c=%0d actual=%b required=%b", c, ld_ret_ready, m_ready()); end
      checks++; if (stall !== m_stall()) begin errors++; $display("FAIL rnd_stall c=%0d actual=%b required=%b", c, stall, m_stall()); end
      checks++; if (reg_out !== m_regout()) begin errors++; $display("FAIL rnd_reg_out c=%0d actual=%h required=%h", c, reg_out, m_regout()); end
      checks++; if (acc_out !== m_reg[0]) begin errors++; $display("FAIL rnd_acc c=%0d actual=%h required=%h", c, acc_out, m_reg[0]); end
      checks++; if (outstanding !== 5'(m_out)) begin errors++; $display("FAIL rnd_outstanding c=%0d actual=%0d required=%0d", c, outstanding, m_out); end
      checks++; if (err !== m_err) begin errors++; $display("FAIL rnd_err c=%0d actual=%b required=%b", c, err, m_err); end
      step();
    end
  endtask

  initial begin
    rst_n = 0;
    drive(0, 0, 0, 0, 4'h0, 8'h00, 0, 4'h0, 8'h00);
    model_clear();
    repeat (2) @(negedge clk);
    rst_n = 1;
    test_random(40);
    test_reset();
    test_acc_priority();
    test_load_bypass();
    test_imme();
    test_ret_conflict();
    test_reset();
    test_stale_ret();
    test_reset();
    test_random(600);
    test_reset();
    test_random(100);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
